// File: rtl/layer_serializer.sv
// Transmit side of the layer word stream: takes one INPUT_SIZE-word vector in parallel
// and emits it one signed word per valid/ready handshake, back-to-back without bubbles.
module layer_serializer #(
  parameter int unsigned INPUT_SIZE = 10,
  parameter int unsigned WORD_SIZE  = 16
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [INPUT_SIZE*WORD_SIZE-1:0]  data_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [WORD_SIZE-1:0]             data_r_o,
  output logic                             last_o
);

  localparam int unsigned VEC_W = INPUT_SIZE * WORD_SIZE;
  localparam int unsigned CNT_W = (INPUT_SIZE > 2) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(INPUT_SIZE - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VEC_W-1:0]   buf_q, buf_d;
  logic               last_q, last_d;
  logic               accept;
  logic               xfer;

  // The only combinational input-to-output path: a last-word transfer frees the buffer.
  assign ready_o  = reset_n_i && ((state_q == EMPTY) || (last_q && ready_i));
  assign valid_o  = (state_q == SEND);
  assign last_o   = last_q;
  // The buffer shifts down on each transfer, so the current word always sits at the bottom.
  assign data_r_o = buf_q[WORD_SIZE-1:0];

  assign accept = valid_i && ready_o;
  assign xfer   = (state_q == SEND) && ready_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    last_d  = last_q;
    if (accept) begin
      // Covers both an idle load and the reload on the final word's transfer.
      state_d = SEND;
      cnt_d   = '0;
      buf_d   = data_i;
      last_d  = 1'b0;
    end else if (xfer) begin
      if (last_q) begin
        state_d = EMPTY;
        cnt_d   = '0;
        last_d  = 1'b0;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        buf_d  = {{WORD_SIZE{1'b0}}, buf_q[VEC_W-1:WORD_SIZE]};
        last_d = (cnt_d == LAST_IDX);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      buf_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      last_q  <= last_d;
    end
  end

endmodule
